mux4_rr_feeder: RTL and testbench

Upstream feeder for the 4:1 datapath mux. It captures words from four independent valid/ready producer channels into one-entry holding registers. It drives those registers on d0..d3 and selects among them with a round-robin arbiter that drives the 2-bit select s. A valid/ready handshake to the consumer of the mux output y marks when the selected word has been taken.

---
 rtl/mux4_rr_feeder.sv | 137 +++++++++++++
 tb/tb_mux4_rr_feeder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mux4_rr_feeder.sv
// Four-channel valid/ready feeder for a 4:1 mux: one-entry holding register per
// channel, round-robin select and a valid/ready handshake on the mux output.
module mux4_rr_feeder #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [3:0]       in_valid,
   output logic [3:0]       in_ready,
   input  logic [WIDTH-1:0] in_data0,
   input  logic [WIDTH-1:0] in_data1,
   input  logic [WIDTH-1:0] in_data2,
   input  logic [WIDTH-1:0] in_data3,
   output logic [WIDTH-1:0] d0,
   output logic [WIDTH-1:0] d1,
   output logic [WIDTH-1:0] d2,
   output logic [WIDTH-1:0] d3,
   output logic [1:0]       s,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [CNT_W-1:0] xfer_cnt
);

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_PRESENT = 1'b1
   } state_t;

   state_t           r_state;
   logic [3:0]       r_full;
   logic [WIDTH-1:0] r_hold0;
   logic [WIDTH-1:0] r_hold1;
   logic [WIDTH-1:0] r_hold2;
   logic [WIDTH-1:0] r_hold3;
   logic [1:0]       r_s;
   logic             r_out_valid;
   logic [CNT_W-1:0] r_xfer_cnt;
   logic [1:0]       r_last_grant;

   logic       w_hs;
   logic [3:0] w_cap;
   logic [3:0] w_drain;
   logic [3:0] w_pending;
   logic [1:0] w_base;
   logic [1:0] w_cand;
   logic [1:0] w_pick;
   logic       w_any;

   assign w_hs    = r_out_valid & out_ready;
   assign w_cap   = in_valid & ~r_full;
   assign w_drain = w_hs ? (4'b0001 << r_s) : 4'b0000;

   // While presenting, the word being taken is excluded and the search starts after it.
   always_comb begin
      w_pending = r_full;
      w_base    = r_last_grant;
      if (r_state == ST_PRESENT) begin
         w_pending = r_full & ~(4'b0001 << r_s);
         w_base    = r_s;
      end
   end

   // Round-robin search base+1..base+4; scanning downward lets the nearest hit win.
   always_comb begin
      w_pick = w_base;
      w_any  = 1'b0;
      w_cand = w_base;
      for (int k = 4; k >= 1; k--) begin
         w_cand = w_base + 2'(k);
         if (w_pending[w_cand]) begin
            w_pick = w_cand;
            w_any  = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state      <= ST_IDLE;
         r_full       <= 4'b0000;
         r_hold0      <= '0;
         r_hold1      <= '0;
         r_hold2      <= '0;
         r_hold3      <= '0;
         r_s          <= 2'd0;
         r_out_valid  <= 1'b0;
         r_xfer_cnt   <= '0;
         r_last_grant <= 2'd3;
      end else begin
         if (w_cap[0]) r_hold0 <= in_data0;
         if (w_cap[1]) r_hold1 <= in_data1;
         if (w_cap[2]) r_hold2 <= in_data2;
         if (w_cap[3]) r_hold3 <= in_data3;
         r_full <= (r_full | w_cap) & ~w_drain;

         if (w_hs) begin
            r_last_grant <= r_s;
            r_xfer_cnt   <= r_xfer_cnt + CNT_W'(1);
         end

         case (r_state)
            ST_IDLE: begin
               if (w_any) begin
                  r_s         <= w_pick;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_PRESENT;
               end
            end
            ST_PRESENT: begin
               if (w_hs) begin
                  if (w_any) begin
                     r_s <= w_pick;
                  end else begin
                     r_out_valid <= 1'b0;
                     r_state     <= ST_IDLE;
                  end
               end
            end
            default: begin
               r_out_valid <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = ~r_full;
   assign d0        = r_hold0;
   assign d1        = r_hold1;
   assign d2        = r_hold2;
   assign d3        = r_hold3;
   assign s         = r_s;
   assign out_valid = r_out_valid;
   assign xfer_cnt  = r_xfer_cnt;

endmodule

// File: tb/tb_mux4_rr_feeder.sv
// Randomized and directed bench for mux4_rr_feeder against a per-transaction
// behavioural model (queue-free slot array plus a "last granted channel" index).
module tb_mux4_rr_feeder;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [3:0] in_valid;
   logic [3:0] in_ready;
   logic [3:0] in_data0, in_data1, in_data2, in_data3;
   logic [3:0] d0, d1, d2, d3;
   logic [1:0] s;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] xfer_cnt;

   int checks = 0;
   int errors = 0;

   // model state
   bit [3:0] m_full;
   bit [3:0] m_hold [4];
   bit       m_pres;
   int       m_sel;
   int       m_last;
   int       m_cnt;
   int       n_hs;

   always #5 clk = ~clk;

   mux4_rr_feeder #(.WIDTH(4), .CNT_W(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_data0(in_data0), .in_data1(in_data1), .in_data2(in_data2), .in_data3(in_data3),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3),
      .s(s), .out_valid(out_valid), .out_ready(out_ready), .xfer_cnt(xfer_cnt)
   );

   function automatic int pick(input bit [3:0] p, input int base);
      for (int k = 1; k <= 4; k++) begin
         if (p[(base + k) % 4]) return (base + k) % 4;
      end
      return -1;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic model_step(input logic [3:0] iv, input logic [15:0] dat,
                             input logic ordy, input logic rn);
      bit [3:0] nf;
      bit [3:0] p;
      bit       hs;
      if (!rn) begin
         m_full = '0;
         for (int i = 0; i < 4; i++) m_hold[i] = '0;
         m_pres = 0; m_sel = 0; m_last = 3; m_cnt = 0;
         return;
      end
      hs = m_pres && ordy;
      nf = m_full;
      for (int i = 0; i < 4; i++) begin
         if (iv[i] && !m_full[i]) begin
            nf[i] = 1'b1;
            m_hold[i] = dat[4*i +: 4];
         end
      end
      if (hs) begin
         nf[m_sel] = 1'b0;
         m_last = m_sel;
         m_cnt = (m_cnt + 1) % 256;
         n_hs++;
      end
      if (!m_pres) begin
         if (m_full != 0) begin
            m_sel = pick(m_full, m_last);
            m_pres = 1;
         end
      end else if (hs) begin
         p = m_full;
         p[m_sel] = 1'b0;
         if (p != 0) m_sel = pick(p, m_sel);
         else        m_pres = 0;
      end
      m_full = nf;
   endtask

   task automatic compare_all();
      logic [3:0] exp_rdy;
      exp_rdy = ~m_full;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(m_pres));
      chk("s", 32'(s), 32'(m_sel));
      chk("xfer_cnt", 32'(xfer_cnt), 32'(m_cnt));
      chk("d0", 32'(d0), 32'(m_hold[0]));
      chk("d1", 32'(d1), 32'(m_hold[1]));
      chk("d2", 32'(d2), 32'(m_hold[2]));
      chk("d3", 32'(d3), 32'(m_hold[3]));
   endtask

   task automatic step(input logic [3:0] iv, input logic [15:0] dat,
                       input logic ordy, input logic rn);
      in_valid  = iv;
      in_data0  = dat[3:0];
      in_data1  = dat[7:4];
      in_data2  = dat[11:8];
      in_data3  = dat[15:12];
      out_ready = ordy;
      rst_n     = rn;
      model_step(iv, dat, ordy, rn);
      @(posedge clk);
      #1;
      compare_all();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = '0; out_ready = 1'b0;
      in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
      n_hs = 0;

      // reset state
      step(4'h0, 16'h0, 1'b0, 1'b0);
      step(4'h0, 16'h0, 1'b0, 1'b0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'hf);
      chk("rst_xfer", 32'(xfer_cnt), 32'd0);

      // single word on channel 2
      step(4'b0100, 16'h0A00, 1'b0, 1'b1);
      chk("single_in_ready", 32'(in_ready), 32'b1011);
      step(4'h0, 16'h0, 1'b1, 1'b1);
      chk("single_s", 32'(s), 32'd2);
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_d2", 32'(d2), 32'hA);
      step(4'h0, 16'h0, 1'b1, 1'b1);
      chk("single_done_valid", 32'(out_valid), 32'd0);
      chk("single_done_rdy", 32'(in_ready), 32'hf);
      chk("single_done_cnt", 32'(xfer_cnt), 32'd1);

      // all four at once after a fresh reset: rotation 0,1,2,3 without bubble
      step(4'h0, 16'h0, 1'b0, 1'b0);
      step(4'hf, 16'h4321, 1'b1, 1'b1);
      for (int k = 0; k < 4; k++) begin
         step(4'h0, 16'h0, 1'b1, 1'b1);
         chk("all4_s", 32'(s), 32'(k));
         chk("all4_valid", 32'(out_valid), 32'd1);
      end
      step(4'h0, 16'h0, 1'b1, 1'b1);
      chk("all4_cnt", 32'(xfer_cnt), 32'd4);
      chk("all4_valid_end", 32'(out_valid), 32'd0);

      // backpressure on channel 1
      step(4'b0010, 16'h0050, 1'b0, 1'b1);
      step(4'b0010, 16'h0090, 1'b0, 1'b1);
      for (int k = 0; k < 5; k++) begin
         step(4'b0010, 16'h0090, 1'b0, 1'b1);
         chk("bp_s", 32'(s), 32'd1);
         chk("bp_valid", 32'(out_valid), 32'd1);
         chk("bp_rdy1", 32'(in_ready[1]), 32'd0);
         chk("bp_d1", 32'(d1), 32'h5);
      end
      step(4'b0010, 16'h0090, 1'b1, 1'b1);
      chk("bp_hs_rdy", 32'(in_ready), 32'hf);
      chk("bp_hs_d1", 32'(d1), 32'h5);
      step(4'b0010, 16'h0060, 1'b0, 1'b1);
      chk("bp_refill_rdy", 32'(in_ready), 32'b1101);
      chk("bp_refill_d1", 32'(d1), 32'h6);
      step(4'h0, 16'h0, 1'b1, 1'b1);
      step(4'h0, 16'h0, 1'b1, 1'b1);

      // round-robin resume from last grant 1
      step(4'b1001, 16'h7008, 1'b0, 1'b1);
      step(4'h0, 16'h0, 1'b0, 1'b1);
      chk("rr_first", 32'(s), 32'd3);
      step(4'h0, 16'h0, 1'b1, 1'b1);
      chk("rr_second", 32'(s), 32'd0);
      chk("rr_valid", 32'(out_valid), 32'd1);
      step(4'h0, 16'h0, 1'b1, 1'b1);
      chk("rr_cnt", 32'(xfer_cnt), 32'd8);

      // reset mid-operation
      step(4'b0111, 16'h0BCD, 1'b0, 1'b1);
      step(4'h0, 16'h0, 1'b0, 1'b1);
      chk("mid_valid_pre", 32'(out_valid), 32'd1);
      step(4'h0, 16'h0, 1'b1, 1'b0);
      chk("mid_rdy", 32'(in_ready), 32'hf);
      chk("mid_valid", 32'(out_valid), 32'd0);
      chk("mid_cnt", 32'(xfer_cnt), 32'd0);
      chk("mid_d2", 32'(d2), 32'd0);
      for (int k = 0; k < 3; k++) begin
         step(4'h0, 16'h0, 1'b1, 1'b1);
         chk("mid_idle", 32'(out_valid), 32'd0);
      end

      // counter wrap after 256 handshakes
      step(4'h0, 16'h0, 1'b0, 1'b0);
      n_hs = 0;
      for (int k = 0; k < 2000 && n_hs < 256; k++) begin
         step(4'hf, 16'($urandom), 1'b1, 1'b1);
      end
      chk("wrap_hs_count", 32'(n_hs), 32'd256);
      chk("wrap_cnt", 32'(xfer_cnt), 32'd0);

      // randomized traffic with occasional reset
      for (int k = 0; k < 3000; k++) begin
         step(4'($urandom), 16'($urandom), 1'($urandom),
              ($urandom_range(0, 199) != 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
